// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the BCD stopwatch
// Purpose: control-state enum, BCD digit type and digit limits used by
//          stopwatch_bcd and bcd_digit.
// Ports:   none (package)
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX    = 9;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one up/down BCD digit with carry/borrow for cascading
// Purpose: a single decimal digit counting 0..MAX, stepping on en in the
//          direction given by up, wrapping at the limits.
// Ports:   clk, rst (async, active high)
//          en     - step this digit in the current cycle
//          up     - 1 = increment, 0 = decrement
//          clr    - synchronous clear to 0, overrides en
//          q      - digit value
//          carry  - en & up & at MAX   (next digit must step up)
//          borrow - en & ~up & at 0    (next digit must step down)
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic up,
  input  logic clr,
  output bcd_t q,
  output logic carry,
  output logic borrow
);

  localparam bcd_t TOP = bcd_t'(MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      if (up) begin
        q <= (q == TOP) ? '0 : q + 4'd1;
      end else begin
        q <= (q == '0) ? TOP : q - 4'd1;
      end
    end
  end

  assign carry  = en & up & (q == TOP);
  assign borrow = en & ~up & (q == '0);

endmodule

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - MM:SS BCD stopwatch with run/pause control and optional lap hold
// Purpose: counts 1 Hz ticks up or down in BCD, MM from 00 to MIN_MAX.
//          Optional lap hold compiled in when STOPWATCH_LAP_EN is defined.
// Ports:   clk, rst (async, active high)
//          tick       - 1 Hz enable pulse
//          start_stop - toggles IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//          clr        - zero the count and return to IDLE (highest priority)
//          up         - direction level, 1 = up
//          lap        - toggles the display hold (lap build only)
//          sec0, sec1, min0, min1 - BCD display digits
//          running    - state is RUN
//          wrap       - one-cycle pulse on rollover MIN_MAX:59 -> 00:00
//          done       - one-cycle pulse when a down-count ends at 00:00
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clr,
  input  logic       up,
  input  logic       lap,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic       running,
  output logic       wrap,
  output logic       done
);

  localparam bcd_t MIN_TENS_MAX = bcd_t'(MIN_MAX / 10);
  localparam bcd_t MIN_ONES_MAX = bcd_t'(MIN_MAX % 10);

  state_t state, state_next;
  bcd_t   ls0, ls1, lm0, lm1;
  logic   c0, c1, c2, c3, b0, b1, b2, b3;
  logic   count_en, at_top, at_zero, at_one;
  logic   wrap_hit, done_hit, digits_clr;
  logic [15:0] live;

  assign count_en = tick & (state == RUN) & ~clr;

  assign at_zero = (lm1 == '0) && (lm0 == '0) && (ls1 == '0) && (ls0 == '0);
  assign at_one  = (lm1 == '0) && (lm0 == '0) && (ls1 == '0) && (ls0 == 4'd1);
  assign at_top  = (lm1 == MIN_TENS_MAX) && (lm0 == MIN_ONES_MAX) &&
                   (ls1 == bcd_t'(SEC_TENS_MAX)) && (ls0 == bcd_t'(DIGIT_MAX));

  assign wrap_hit = count_en & up & at_top;
  // Down-count from 00:01 or 00:00 both end at 00:00; loading zero covers
  // both and keeps the digits from borrowing past 00:00.
  assign done_hit   = count_en & ~up & (at_zero | at_one);
  assign digits_clr = clr | wrap_hit | done_hit;

  // Minute ones count to 9 as a plain digit; the MIN_MAX:59 limit is
  // enforced by digits_clr, so the minutes never pass MIN_MAX.
  bcd_digit #(.MAX(DIGIT_MAX)) u_sec0 (
    .clk(clk), .rst(rst), .en(count_en), .up(up), .clr(digits_clr),
    .q(ls0), .carry(c0), .borrow(b0));
  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec1 (
    .clk(clk), .rst(rst), .en(c0 | b0), .up(up), .clr(digits_clr),
    .q(ls1), .carry(c1), .borrow(b1));
  bcd_digit #(.MAX(DIGIT_MAX)) u_min0 (
    .clk(clk), .rst(rst), .en(c1 | b1), .up(up), .clr(digits_clr),
    .q(lm0), .carry(c2), .borrow(b2));
  bcd_digit #(.MAX(MIN_MAX / 10)) u_min1 (
    .clk(clk), .rst(rst), .en(c2 | b2), .up(up), .clr(digits_clr),
    .q(lm1), .carry(c3), .borrow(b3));

  logic carry_unused;
  assign carry_unused = c3 | b3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      wrap  <= wrap_hit;
      done  <= done_hit;
    end
  end

  always_comb begin
    state_next = state;
    if (clr || done_hit) begin
      state_next = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign live    = {lm1, lm0, ls1, ls0};

`ifdef STOPWATCH_LAP_EN
  logic        hold_on;
  logic [15:0] hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_on <= 1'b0;
      hold_q  <= '0;
    end else if (clr) begin
      hold_on <= 1'b0;
    end else if (lap) begin
      if (hold_on) begin
        hold_on <= 1'b0;
      end else begin
        hold_on <= 1'b1;
        hold_q  <= live;
      end
    end
  end

  assign {min1, min0, sec1, sec0} = hold_on ? hold_q : live;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign {min1, min0, sec1, sec0} = live;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - self-checking bench for stopwatch_bcd
module tb_stopwatch_bcd;

  localparam int MIN_MAX = 59;
  localparam int TOP_SEC = MIN_MAX * 60 + 59;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, start_stop = 1'b0, clr = 1'b0, up = 1'b1, lap = 1'b0;
  logic [3:0] sec0, sec1, min0, min1;
  logic       running, wrap, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: count kept as whole seconds, mode as a small integer
  // (0 = idle, 1 = run, 2 = pause).
  int m_cnt = 0, m_held = 0, m_mode = 0;
  bit m_hold = 0, m_wrap = 0, m_done = 0;

  stopwatch_bcd #(.MIN_MAX(MIN_MAX)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clr(clr),
    .up(up), .lap(lap), .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
    .running(running), .wrap(wrap), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [15:0] disp();
    return {min1, min0, sec1, sec0};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_held = 0; m_mode = 0; m_hold = 0; m_wrap = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit t, input bit ss, input bit c, input bit u, input bit l);
    int nxt;
    m_wrap = 0;
    m_done = 0;
    if (c) begin
      m_mode = 0;
      m_cnt  = 0;
      m_hold = 0;
    end else begin
      if (LAP_EN && l) begin
        if (m_hold) m_hold = 0;
        else begin
          m_hold = 1;
          m_held = m_cnt;
        end
      end
      nxt = m_mode;
      if (ss) nxt = (m_mode == 1) ? 2 : 1;
      if (t && m_mode == 1) begin
        if (u) begin
          if (m_cnt == TOP_SEC) begin m_cnt = 0; m_wrap = 1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt <= 1) begin m_cnt = 0; m_done = 1; nxt = 0; end
          else m_cnt = m_cnt - 1;
        end
      end
      m_mode = nxt;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".digits"}, disp(), to_bcd(m_hold ? m_held : m_cnt));
    check({tag, ".running"}, 16'(running), 16'(m_mode == 1));
    check({tag, ".wrap"}, 16'(wrap), 16'(m_wrap));
    check({tag, ".done"}, 16'(done), 16'(m_done));
  endtask

  // Called #1 after a rising edge; applies inputs for the next edge.
  task automatic step(input bit t, input bit ss, input bit c, input bit l);
    tick = t; start_stop = ss; clr = c; lap = l;
    model_edge(t, ss, c, up, l);
    @(posedge clk);
    #1;
    tick = 0; start_stop = 0; clr = 0; lap = 0;
    compare_all("step");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("reset.digits", disp(), 16'h0000);
    check("reset.running", 16'(running), 16'h0);
    check("reset.pulses", {14'b0, wrap, done}, 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // 61 ticks up from reset -> 01:01
    up = 1;
    step(0, 1, 0, 0);
    ticks(61);
    check("up61.digits", disp(), 16'h0101);
    check("up61.running", 16'(running), 16'h1);

    // climb to 59:59, then one tick rolls over with a single-cycle wrap
    ticks(TOP_SEC - 61);
    check("top.digits", disp(), 16'h5959);
    ticks(1);
    check("wrap.digits", disp(), 16'h0000);
    check("wrap.pulse", 16'(wrap), 16'h1);
    check("wrap.running", 16'(running), 16'h1);
    step(0, 0, 0, 0);
    check("wrap.one_cycle", 16'(wrap), 16'h0);

    // down from 00:02
    ticks(2);
    check("pre_down.digits", disp(), 16'h0002);
    up = 0;
    ticks(1);
    check("down1.digits", disp(), 16'h0001);
    check("down1.done", 16'(done), 16'h0);
    ticks(1);
    check("down0.digits", disp(), 16'h0000);
    check("down0.done", 16'(done), 16'h1);
    check("down0.running", 16'(running), 16'h0);
    ticks(1);
    check("down_after.digits", disp(), 16'h0000);
    check("down_after.done", 16'(done), 16'h0);

    // clr beats start_stop and tick in the same cycle
    up = 1;
    step(0, 1, 0, 0);
    ticks(3);
    check("pre_clr.digits", disp(), 16'h0003);
    step(1, 1, 1, 0);
    check("clr.digits", disp(), 16'h0000);
    check("clr.running", 16'(running), 16'h0);
    ticks(1);
    check("clr_after.digits", disp(), 16'h0000);

    // pause holds the count
    step(0, 1, 0, 0);
    ticks(10);
    step(0, 1, 0, 0);
    check("pause.running", 16'(running), 16'h0);
    ticks(5);
    check("pause.digits", disp(), 16'h0010);
    step(0, 1, 0, 0);
    ticks(1);
    check("resume.digits", disp(), 16'h0011);

`ifdef STOPWATCH_LAP_EN
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    ticks(5);
    step(0, 0, 0, 1);
    ticks(3);
    check("lap_hold.digits", disp(), 16'h0005);
    step(0, 0, 0, 1);
    check("lap_release.digits", disp(), 16'h0008);
`endif

    // randomized traffic against the model, with occasional mid-run reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) up = ~up;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("rst_async");
        tick = 1; start_stop = 1; lap = 1;
        @(posedge clk);
        #1;
        tick = 0; start_stop = 0; lap = 0;
        compare_all("rst_hold");
        rst = 1'b0;
      end else begin
        step($urandom_range(0, 1) == 1,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 63) == 0,
             $urandom_range(0, 15) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter MIN_MAX, default 59, maximum minute value (1..99).
REQ-002 SHALL have port clk  input  1  single system clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tick  input  1  one-cycle 1 Hz enable pulse from the upstream prescaler's tic.
REQ-005 SHALL have port start_stop  input  1  one-cycle pulse, toggles running.
REQ-006 SHALL have port clr  input  1  one-cycle pulse, zero and halt.
REQ-007 SHALL have port up  input  1  direction level; 1 = count up, 0 = count down.
REQ-008 SHALL have port lap  input  1  one-cycle pulse, toggles display hold (see Configuration).
REQ-009 SHALL have ports sec0, sec1, min0, min1  output  4 each  BCD display digits.
REQ-010 SHALL have port running  output  1  high when state is RUN.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on up-count rollover.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a down-count reaches 00:00.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE, with running = (state == RUN).
REQ-014 SHALL go IDLE->RUN, RUN->PAUSE and PAUSE->RUN on start_stop.
REQ-015 SHALL, on clr in any state, go to IDLE and zero the live count on the next edge.
REQ-016 SHALL give clr priority over start_stop, tick and lap in the same cycle.
REQ-017 SHALL advance the live count only when tick=1 and the registered state is RUN; a tick coinciding with start_stop from IDLE/PAUSE does not count.
REQ-018 SHALL update the digits on the clock edge that samples tick (one-cycle latency).
REQ-019 SHALL step sec0 0..9, sec1 0..5, and the minutes 00..MIN_MAX in BCD, with carry up and borrow down.
REQ-020 SHALL, on an up-count from MIN_MAX:59, load 00:00, pulse wrap and stay in RUN.
REQ-021 SHALL, on a down-count from 00:01, load 00:00, pulse done and go to IDLE.
REQ-022 SHALL, when a down-count tick arrives at 00:00 in RUN, hold 00:00, pulse done and go to IDLE.
REQ-023 SHALL apply a change of up on the next counted tick; no count change results from toggling up alone.
REQ-024 SHALL never produce a digit value above 9, sec1 above 5, or minutes above MIN_MAX.

Reset
REQ-025 SHALL, on rst, asynchronously force state IDLE, all digits 0, running/wrap/done 0 and the hold released.
REQ-026 SHALL, on rst asserted mid-count, discard any pending tick or pulse and resume from IDLE only after rst deasserts.

Configuration
REQ-027 SHALL recognise the macro STOPWATCH_LAP_EN.
REQ-028 SHALL, with STOPWATCH_LAP_EN defined: the first lap pulse captures the live count into a hold register and the outputs show the held value; the second lap pulse releases the hold. Counting continues throughout, and clr also releases the hold.
REQ-029 SHALL, without STOPWATCH_LAP_EN: ignore lap, compile no hold register, and drive the outputs directly from the live count.

Structure
REQ-030 SHALL take the state enum, the 4-bit BCD digit typedef and the constants (SEC_TENS_MAX=5, DIGIT_MAX=9) from package stopwatch_pkg.
REQ-031 SHALL instantiate sub-module bcd_digit (params: max value; ports: clk, rst, en, up, clr, q, carry, borrow) once per digit, cascaded through carry/borrow.

Verification
REQ-032 SHALL verify: rst, start_stop, 61 ticks, up=1 -> 01:01, running=1.
REQ-033 SHALL verify: MIN_MAX=59, preload by counting to 59:59, one tick -> 00:00, wrap high for exactly 1 cycle, state RUN.
REQ-034 SHALL verify: up=0 from 00:02, 2 ticks -> 00:00, done pulse 1 cycle, running=0; a further tick -> no change.
REQ-035 SHALL verify: clr, start_stop and tick in the same cycle -> IDLE, 00:00, no count.
REQ-036 SHALL verify: PAUSE at 00:10, 5 ticks -> still 00:10; start_stop then 1 tick -> 00:11.
REQ-037 SHALL verify, with STOPWATCH_LAP_EN: lap at 00:05, 3 ticks -> outputs 00:05; lap -> outputs 00:08.
